// File: rtl/bit_serializer_if.sv
// Parallel-word ingress and serial-bit egress of the bit serializer.
// The master side feeds words; the slave side is the serializer itself.
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             sof;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  x,
        input  x_valid,
        input  sof
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output x,
        output x_valid,
        output sof
    );
endinterface

// File: rtl/bit_serializer.sv
// Serializes WIDTH-bit words onto x, one bit per clk; first bit in the cycle after acceptance.
// Backpressure: one-word hold buffer, so din_ready drops only while hold is occupied.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic            clk,
    input  logic            clr,
    bit_serializer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [CW-1:0]    r_cnt;
    logic             r_en;

    logic             w_rdy;
    logic             w_xfer;
    logic             w_last;
    logic [WIDTH-1:0] w_sh_next;

    // r_en holds din_ready low until the first edge after reset is released
    assign w_rdy     = r_en && !r_hold_full;
    assign w_xfer    = bus.din_valid && w_rdy;
    assign w_last    = (r_cnt == LAST);
    assign w_sh_next = (MSB_FIRST != 0) ? {r_sh[WIDTH-2:0], 1'b0}
                                        : {1'b0, r_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_en        <= 1'b0;
        end else begin
            r_en <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_sh    <= bus.din;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (!w_last) begin
                        r_sh  <= w_sh_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_xfer) begin
                            r_hold      <= bus.din;
                            r_hold_full <= 1'b1;
                        end
                    end else begin
                        // Word boundary: held word first, else direct bypass, else go idle
                        r_cnt <= '0;
                        if (r_hold_full) begin
                            r_sh        <= r_hold;
                            r_hold_full <= 1'b0;
                        end else if (w_xfer) begin
                            r_sh <= bus.din;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.din_ready = w_rdy;
    assign bus.x_valid   = (r_state == S_SHIFT);
    assign bus.sof       = (r_state == S_SHIFT) && (r_cnt == '0);
    assign bus.x         = (r_state == S_SHIFT)
                         ? ((MSB_FIRST != 0) ? r_sh[WIDTH-1] : r_sh[0])
                         : IDLE_BIT;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed vector bench for bit_serializer: MSB-first and LSB-first instances share clk/clr.
module tb_bit_serializer;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    bit_serializer_if #(.WIDTH(8)) bm ();
    bit_serializer_if #(.WIDTH(8)) bl ();

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u_msb (
        .clk (clk),
        .clr (clr),
        .bus (bm.slave)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u_lsb (
        .clk (clk),
        .clr (clr),
        .bus (bl.slave)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int step, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %b expected %b", name, step, act, exp);
    endtask

    // Expected outputs at a negedge, then inputs driven for the following posedge
    typedef struct {
        logic       x;
        logic       xv;
        logic       sof;
        logic       rdy;
        logic [7:0] din;
        logic       vld;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic x, input logic xv, input logic sof, input logic rdy,
                       input logic [7:0] din, input logic vld);
        vec_t v;
        v.x = x; v.xv = xv; v.sof = sof; v.rdy = rdy; v.din = din; v.vld = vld;
        tbl.push_back(v);
    endtask

    initial begin
        logic [7:0]  w_b2;
        logic [15:0] w_pair;
        logic [7:0]  w_0f;

        w_b2   = 8'b1011_0010;
        w_pair = 16'b1011_0010_0100_1101;
        w_0f   = 8'b0000_1111;

        // Single word followed by a stall
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b1);
        for (int i = 0; i < 8; i++) add(w_b2[7-i], 1'b1, i == 0, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Back-to-back through hold; 8'hFF offered while full must be ignored
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b1);
        add(w_pair[15], 1'b1, 1'b1, 1'b1, 8'h4D, 1'b1);
        for (int i = 1; i < 8; i++) add(w_pair[15-i], 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
        add(w_pair[7], 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 9; i < 16; i++) add(w_pair[15-i], 1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Bypass: second word offered only during the last bit with hold empty
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b1);
        for (int i = 0; i < 7; i++) add(w_pair[15-i], 1'b1, i == 0, 1'b1, 8'h00, 1'b0);
        add(w_pair[8], 1'b1, 1'b0, 1'b1, 8'h4D, 1'b1);
        for (int i = 8; i < 16; i++) add(w_pair[15-i], 1'b1, i == 8, 1'b1, 8'h00, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

        // Reset
        clr = 1'b1;
        bm.din = 8'h00; bm.din_valid = 1'b0;
        bl.din = 8'h00; bl.din_valid = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_x",       c, bm.x,         1'b0);
            chk("rst_xv",      c, bm.x_valid,   1'b0);
            chk("rst_sof",     c, bm.sof,       1'b0);
            chk("rst_rdy",     c, bm.din_ready, 1'b0);
            chk("rst_lsb_rdy", c, bl.din_ready, 1'b0);
        end
        clr = 1'b0;
        #1;
        chk("rdy_before_edge", 0, bm.din_ready, 1'b0);

        foreach (tbl[i]) begin
            @(negedge clk);
            chk("x",   i, bm.x,         tbl[i].x);
            chk("xv",  i, bm.x_valid,   tbl[i].xv);
            chk("sof", i, bm.sof,       tbl[i].sof);
            chk("rdy", i, bm.din_ready, tbl[i].rdy);
            bm.din       = tbl[i].din;
            bm.din_valid = tbl[i].vld;
        end

        // LSB-first: 8'h01 sends a single 1 then seven 0s
        @(negedge clk);
        bl.din = 8'h01; bl.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bl.din_valid = 1'b0;
            chk("lsb_x",   i, bl.x,       i == 0);
            chk("lsb_xv",  i, bl.x_valid, 1'b1);
            chk("lsb_sof", i, bl.sof,     i == 0);
        end
        @(negedge clk);
        chk("lsb_idle_xv", 8, bl.x_valid, 1'b0);

        // Mid-word reset with a word parked in hold
        bm.din = 8'hFF; bm.din_valid = 1'b1;
        @(negedge clk);
        bm.din = 8'hAA; bm.din_valid = 1'b1;
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            bm.din_valid = 1'b0;
        end
        chk("mid_x_bit4",  4, bm.x,         1'b1);
        chk("mid_xv_bit4", 4, bm.x_valid,   1'b1);
        chk("mid_rdy_hold", 4, bm.din_ready, 1'b0);
        #2 clr = 1'b1;
        #1;
        chk("mid_async_xv",  0, bm.x_valid,   1'b0);
        chk("mid_async_x",   0, bm.x,         1'b0);
        chk("mid_async_rdy", 0, bm.din_ready, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_xv", i, bm.x_valid, 1'b0);
        end
        chk("post_rst_rdy", 0, bm.din_ready, 1'b1);
        bm.din = 8'h0F; bm.din_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bm.din_valid = 1'b0;
            chk("w0f_x",   i, bm.x,       w_0f[7-i]);
            chk("w0f_xv",  i, bm.x_valid, 1'b1);
            chk("w0f_sof", i, bm.sof,     i == 0);
        end
        @(negedge clk);
        chk("w0f_idle_xv", 8, bm.x_valid, 1'b0);
        chk("w0f_idle_x",  8, bm.x,       1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
